segment_led_interface: RTL and testbench



---
 rtl/seg7_pkg.sv | 20 ++
 rtl/segment_led_interface_if.sv | 36 +++
 rtl/sync_bit.sv | 25 ++
 rtl/segment_led_interface.sv | 79 +++++++
 tb/tb_segment_led_interface.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment types and encodings for the clip-number display.
// Segment order is a..g from MSB to LSB, active-low.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_ONE   = 7'b1001111;
  localparam seg_t SEG_TWO   = 7'b0010010;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_ALL   = 7'b0000000;

  function automatic seg_t clip_to_seg(input logic clip);
    case (clip)
      1'b0:    return SEG_ONE;
      1'b1:    return SEG_TWO;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/segment_led_interface_if.sv
// Switch inputs and display pins of the clip-number display.
// lamp_test_n exists only when SEG_LAMP_TEST_EN is defined.
interface segment_led_interface_if;

  logic       switch0;
  logic       switch1;
`ifdef SEG_LAMP_TEST_EN
  logic       lamp_test_n;
`endif
  logic       a0;
  logic       a1;
  logic [6:0] cathode;

  modport master (
`ifdef SEG_LAMP_TEST_EN
    output lamp_test_n,
`endif
    output switch0,
    output switch1,
    input  a0,
    input  a1,
    input  cathode
  );

  modport slave (
`ifdef SEG_LAMP_TEST_EN
    input  lamp_test_n,
`endif
    input  switch0,
    input  switch1,
    output a0,
    output a1,
    output cathode
  );

endinterface

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Async active-low reset loads RST_VAL into every stage.
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ff <= {STAGES{RST_VAL}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/segment_led_interface.sv
// Two-digit multiplexed 7-seg driver: digit 0 = record clip, digit 1 = play clip.
// Define SEG_LAMP_TEST_EN to add the lamp_test_n all-segments-on input.
module segment_led_interface
  import seg7_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100000,
  parameter int SYNC_STAGES    = 2
) (
  input logic                    clock,
  input logic                    reset_n,
  segment_led_interface_if.slave io
);

  localparam int CNT_W = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REFRESH_CYCLES - 1);

  logic             rec_clip;
  logic             play_clip;
  logic [CNT_W-1:0] cnt;
  logic             sel;
  logic             wrap;
  logic             nsel;
  seg_t             nseg;

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_rec (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (io.switch0),
    .q       (rec_clip)
  );

  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_play (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (io.switch1),
    .q       (play_clip)
  );

`ifdef SEG_LAMP_TEST_EN
  logic lamp_n;

  // Resets inactive so the display does not flash all-on after reset.
  sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_lamp (
    .clock   (clock),
    .reset_n (reset_n),
    .d       (io.lamp_test_n),
    .q       (lamp_n)
  );
`endif

  // Outputs are built from next-state select so anode and segments move together.
  always_comb begin
    wrap = (cnt == LAST);
    nsel = sel ^ wrap;
    nseg = clip_to_seg(nsel ? play_clip : rec_clip);
`ifdef SEG_LAMP_TEST_EN
    if (!lamp_n) begin
      nseg = SEG_ALL;
    end
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      sel        <= 1'b0;
      io.a0      <= 1'b0;
      io.a1      <= 1'b1;
      io.cathode <= SEG_ONE;
    end else begin
      cnt        <= wrap ? '0 : cnt + CNT_W'(1);
      sel        <= nsel;
      io.a0      <= nsel;
      io.a1      <= ~nsel;
      io.cathode <= nseg;
    end
  end

endmodule

// File: tb/tb_segment_led_interface.sv
// Directed bench for segment_led_interface with REFRESH_CYCLES=4.
// Expected patterns come from hand-written constants and a refresh-phase model.
module tb_segment_led_interface;

  localparam logic [6:0] ONE = 7'b1001111;
  localparam logic [6:0] TWO = 7'b0010010;
  localparam logic [6:0] ALL = 7'b0000000;

  logic clock;
  logic reset_n;
  int   n_cmp;
  int   n_bad;
  int   m_cnt;
  logic m_sel;
  logic m_lamp;

  segment_led_interface_if bus ();

  segment_led_interface #(
    .REFRESH_CYCLES (4),
    .SYNC_STAGES    (2)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .io      (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [6:0] segx(input logic clip);
    return clip ? TWO : ONE;
  endfunction

  function automatic logic [8:0] expv();
    logic [6:0] s;
    s = m_sel ? segx(bus.switch1) : segx(bus.switch0);
    if (m_lamp) s = ALL;
    return {m_sel, ~m_sel, s};
  endfunction

  task automatic check(input string tag, input logic [8:0] exp);
    logic [8:0] got;
    got = {bus.a0, bus.a1, bus.cathode};
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (m_cnt == 3) begin
      m_cnt = 0;
      m_sel = ~m_sel;
    end else begin
      m_cnt++;
    end
    #1;
  endtask

  task automatic settle_and_check(input string tag, input int n);
    repeat (3) tick();
    for (int i = 0; i < n; i++) begin
      tick();
      check(tag, expv());
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    m_cnt   = 0;
    m_sel   = 1'b0;
    m_lamp  = 1'b0;
    reset_n = 1'b0;
    bus.switch0 = 1'b0;
    bus.switch1 = 1'b0;
`ifdef SEG_LAMP_TEST_EN
    bus.lamp_test_n = 1'b1;
`endif

    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("reset_hold", {1'b0, 1'b1, ONE});
    end
    reset_n = 1'b1;

    for (int i = 1; i <= 3; i++) begin
      tick();
      check("pre_swap", {1'b0, 1'b1, ONE});
    end
    tick();
    check("first_swap", {1'b1, 1'b0, ONE});

    settle_and_check("sw00", 12);

    bus.switch0 = 1'b1;
    bus.switch1 = 1'b0;
    settle_and_check("sw10", 12);

    bus.switch0 = 1'b0;
    bus.switch1 = 1'b1;
    settle_and_check("sw01", 12);

    bus.switch0 = 1'b1;
    bus.switch1 = 1'b1;
    settle_and_check("sw11", 12);

    // Async reset asserted mid-cycle.
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", {1'b0, 1'b1, ONE});
    @(negedge clock);
    check("reset_low", {1'b0, 1'b1, ONE});
    reset_n = 1'b1;
    m_cnt = 0;
    m_sel = 1'b0;
    tick();
    check("refill_1", {1'b0, 1'b1, ONE});
    tick();
    check("refill_2", {1'b0, 1'b1, ONE});
    tick();
    check("refill_3", {1'b0, 1'b1, TWO});
    tick();
    check("refill_4", {1'b1, 1'b0, TWO});

`ifdef SEG_LAMP_TEST_EN
    bus.switch0 = 1'b0;
    bus.lamp_test_n = 1'b0;
    m_lamp = 1'b1;
    settle_and_check("lamp_on", 12);
    bus.lamp_test_n = 1'b1;
    m_lamp = 1'b0;
    settle_and_check("lamp_off", 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
